pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage RV64 core. Drives the stall/bubble inputs
//  of the F/D/E/M/W pipeline registers from hazard sources: data-memory wait,
//  multi-cycle mul/div, branch mispredict and load-use. Tracks multi-cycle waits in an FSM,
//  launches mul/div ops, counts stall cycles and flags memory timeouts.
// PARAMETERS
//  CNT_W      32   width of the stall-cycle performance counter (saturating)
//  TIMEOUT    255  max DMEM_WAIT cycles before timeout_o sets (>=1)
// PORTS
//  clk_i              in   1   clock, rising edge
//  rst_i              in   1   synchronous reset, active-high
//  D_rs1_i/D_rs2_i    in   5   source regs of instruction in D
//  D_rs1_used_i/D_rs2_used_i in 1  source actually read
//  E_rd_i             in   5   dest reg of instruction in E
//  E_reg_wen_i        in   1   E writes rd
//  E_is_load_i        in   1   E is a load
//  E_is_md_i          in   1   E is a mul/div op
//  E_mispredict_i     in   1   branch/jump in E resolved against prediction
//  md_done_i          in   1   mul/div unit result valid (1-cycle pulse)
//  M_mem_req_i        in   1   M stage issuing a data-memory access
//  dmem_ready_i       in   1   data memory completes access this cycle
//  F_stall_o D_stall_o E_stall_o M_stall_o W_stall_o  out 1 each  hold stage register
//  D_bubble_o E_bubble_o M_bubble_o W_bubble_o        out 1 each  load NOP into stage register
//  md_start_o         out  1   launch mul/div (1-cycle pulse)
//  stall_cnt_o        out  CNT_W  cycles with F_stall_o=1, saturates at all-ones
//  timeout_o          out  1   sticky: a DMEM_WAIT lasted > TIMEOUT cycles
// BEHAVIOUR
//  - Reset (rst_i=1, sampled at edge): state=RUN, stall_cnt_o=0, timeout_o=0, wait counter=0.
//    While rst_i=1 the combinational outputs are forced: all *_stall_o=0, D/E/M/W_bubble_o=1,
//    md_start_o=0. Reset mid-wait abandons the wait; no md_start re-issue.
//  - FSM states: RUN, DMEM_WAIT, MD_WAIT (2-bit encoding).
//    RUN->DMEM_WAIT: M_mem_req_i & ~dmem_ready_i.  DMEM_WAIT->RUN: dmem_ready_i.
//    RUN->MD_WAIT: E_is_md_i & no mem hold (md_start_o=1 this cycle). MD_WAIT->RUN: md_done_i.
//    MD_WAIT with mem hold: stay MD_WAIT; a md_done_i arriving then is latched (done_pend)
//    and releases E at the first cycle without mem hold.
//  - mem_hold = M_mem_req_i & ~dmem_ready_i (any state). md_hold = (RUN & E_is_md_i) |
//    (MD_WAIT & ~md_done_i & ~done_pend). Outputs are combinational, same-cycle.
//  - Priority (highest first), exactly one row applies:
//    1 mem_hold:  F,D,E,M stall; W_bubble.
//    2 md_hold:   F,D,E stall; M_bubble.
//    3 E_mispredict_i: D_bubble, E_bubble; no stalls (F takes redirect PC).
//    4 load-use: E_is_load_i & E_reg_wen_i & E_rd_i!=0 & ((D_rs1_used_i & D_rs1_i==E_rd_i)
//      | (D_rs2_used_i & D_rs2_i==E_rd_i)): F,D stall; E_bubble.
//    5 none: all 0.
//  - Mispredict masked while rows 1/2 active; E presents it again when it advances.
//  - W_stall_o tied 0 (W always retires or takes bubble). Stall and bubble of the same stage
//    never both 1.
//  - Wait counter: cleared on entry to DMEM_WAIT, increments each DMEM_WAIT cycle;
//    timeout_o sets when counter reaches TIMEOUT with dmem_ready_i=0; cleared only by reset.
//  - stall_cnt_o += 1 each cycle F_stall_o=1; holds at 2^CNT_W-1.
// STRUCTURE
//  - pipe_pkg: state encoding localparams (ST_RUN/ST_DMEM_WAIT/ST_MD_WAIT), reg-addr width 5.
//  - One sub-module: pipe_sat_counter (CNT_W, inc_i, clr_i) used for stall_cnt_o and the
//    wait counter. Hazard priority logic stays flat in this module.
// TESTING
//  - Load-use: E ld x5, D add x6,x5,x1 (rs1_used) -> 1 cycle F/D_stall=1, E_bubble=1; rd=x0 -> no stall.
//  - Mispredict: E_mispredict_i=1 in RUN -> D_bubble=E_bubble=1, no stall, stall_cnt unchanged.
//  - Mem wait: M_mem_req=1, ready low 3 cycles -> F/D/E/M_stall=1, W_bubble=1 for 3 cycles;
//    state DMEM_WAIT; stall_cnt=3.
//  - Mul/div: E_is_md=1 -> md_start 1 pulse, F/D/E_stall + M_bubble until md_done (cycle 4) -> RUN.
//  - Overlap/timeout: md_done during mem hold -> E released first cycle after ready; TIMEOUT=4,
//    ready low 6 cycles -> timeout_o=1 sticky; rst_i mid-wait -> RUN, counters 0, bubbles=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding, register
// address width and the source/destination dependency test.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_DMEM_WAIT = 2'b01,
        ST_MD_WAIT   = 2'b10
    } state_t;

    function automatic logic src_match(input logic [REG_ADDR_W-1:0] rs,
                                       input logic                  used,
                                       input logic [REG_ADDR_W-1:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: turns memory-wait, mul/div, mispredict and load-use hazards
// into per-stage stall/bubble controls, with a stall-cycle counter and DMEM timeout flag.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] D_rs1_i,
    input  logic [REG_ADDR_W-1:0] D_rs2_i,
    input  logic                  D_rs1_used_i,
    input  logic                  D_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] E_rd_i,
    input  logic                  E_reg_wen_i,
    input  logic                  E_is_load_i,
    input  logic                  E_is_md_i,
    input  logic                  E_mispredict_i,
    input  logic                  md_done_i,
    input  logic                  M_mem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  F_stall_o,
    output logic                  D_stall_o,
    output logic                  E_stall_o,
    output logic                  M_stall_o,
    output logic                  W_stall_o,
    output logic                  D_bubble_o,
    output logic                  E_bubble_o,
    output logic                  M_bubble_o,
    output logic                  W_bubble_o,
    output logic                  md_start_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  timeout_o
);

    // One spare count above TIMEOUT so the saturated value never aliases the limit.
    localparam int                WAIT_W      = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    // state        | meaning
    // ST_RUN       | pipeline flowing; hazards resolved combinationally
    // ST_DMEM_WAIT | M stage blocked on data memory
    // ST_MD_WAIT   | E stage holding a launched mul/div until its result
    state_t state_q, state_d;
    logic   done_pend_q, done_pend_d;
    logic   timeout_q;
    logic   mem_hold, md_launch, md_hold, load_use;
    logic   wait_clr, wait_inc;
    logic [WAIT_W-1:0] wait_cnt;

    assign mem_hold  = M_mem_req_i & ~dmem_ready_i;
    assign md_launch = (state_q == ST_RUN) & E_is_md_i;
    assign md_hold   = md_launch
                     | ((state_q == ST_MD_WAIT) & ~md_done_i & ~done_pend_q);
    assign load_use  = E_is_load_i & E_reg_wen_i & (E_rd_i != '0)
                     & (src_match(D_rs1_i, D_rs1_used_i, E_rd_i)
                      | src_match(D_rs2_i, D_rs2_used_i, E_rd_i));

    always_comb begin
        state_d     = state_q;
        done_pend_d = done_pend_q;
        case (state_q)
            ST_RUN: begin
                if (mem_hold) begin
                    state_d = ST_DMEM_WAIT;
                end else if (E_is_md_i) begin
                    state_d = ST_MD_WAIT;
                end
            end
            ST_DMEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_MD_WAIT: begin
                // A result that lands under a memory hold is remembered, not lost.
                if ((md_done_i | done_pend_q) & ~mem_hold) begin
                    state_d     = ST_RUN;
                    done_pend_d = 1'b0;
                end else if (md_done_i) begin
                    done_pend_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                done_pend_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        E_stall_o  = 1'b0;
        M_stall_o  = 1'b0;
        W_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_bubble_o = 1'b0;
        md_start_o = 1'b0;
        if (rst_i) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
            W_bubble_o = 1'b1;
        end else if (mem_hold) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_stall_o  = 1'b1;
            W_bubble_o = 1'b1;
        end else if (md_hold) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_bubble_o = 1'b1;
            md_start_o = md_launch;
        end else if (E_mispredict_i) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
        end else if (load_use) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            done_pend_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
            if ((state_q == ST_DMEM_WAIT) && (wait_cnt == TIMEOUT_CNT) && !dmem_ready_i) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
    assign wait_clr  = (state_q == ST_RUN) & mem_hold;
    assign wait_inc  = (state_q == ST_DMEM_WAIT);

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (F_stall_o),
        .clr_i (1'b0),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(WAIT_W)) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (wait_inc),
        .clr_i (wait_clr),
        .cnt_o (wait_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against a behavioural
// model of the hazard rules (small counter width and timeout to reach the limits).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] D_rs1_i, D_rs2_i, E_rd_i;
    logic       D_rs1_used_i, D_rs2_used_i, E_reg_wen_i, E_is_load_i, E_is_md_i;
    logic       E_mispredict_i, md_done_i, M_mem_req_i, dmem_ready_i;
    logic       F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o;
    logic       D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o, md_start_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    // Model: what the pipeline is waiting on, as plain flags and counts.
    bit m_mem_wait, m_md_wait, m_md_result;
    int m_wait_len, m_stalls;
    bit m_timeout;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .D_rs1_i(D_rs1_i), .D_rs2_i(D_rs2_i),
        .D_rs1_used_i(D_rs1_used_i), .D_rs2_used_i(D_rs2_used_i),
        .E_rd_i(E_rd_i), .E_reg_wen_i(E_reg_wen_i), .E_is_load_i(E_is_load_i),
        .E_is_md_i(E_is_md_i), .E_mispredict_i(E_mispredict_i), .md_done_i(md_done_i),
        .M_mem_req_i(M_mem_req_i), .dmem_ready_i(dmem_ready_i),
        .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .E_stall_o(E_stall_o),
        .M_stall_o(M_stall_o), .W_stall_o(W_stall_o),
        .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o), .M_bubble_o(M_bubble_o),
        .W_bubble_o(W_bubble_o), .md_start_o(md_start_o),
        .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Bit order: F D E M W stall, D E M W bubble, md_start.
    function automatic logic [9:0] exp_outputs();
        bit mem_block, md_block, dep, start;
        if (rst_i) return 10'b00000_1111_0;
        mem_block = M_mem_req_i && !dmem_ready_i;
        md_block  = (!m_mem_wait && !m_md_wait && E_is_md_i)
                 || (m_md_wait && !md_done_i && !m_md_result);
        start     = !m_mem_wait && !m_md_wait && E_is_md_i;
        dep       = E_is_load_i && E_reg_wen_i && (E_rd_i != 5'd0)
                 && ((D_rs1_used_i && D_rs1_i == E_rd_i) || (D_rs2_used_i && D_rs2_i == E_rd_i));
        if (mem_block)      return 10'b11110_0001_0;
        if (md_block)       return {9'b11100_0010, start};
        if (E_mispredict_i) return 10'b00000_1100_0;
        if (dep)            return 10'b11000_0100_0;
        return 10'b0;
    endfunction

    function automatic logic [9:0] dut_outputs();
        return {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
                D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o, md_start_o};
    endfunction

    task automatic model_update(input logic [9:0] e);
        bit mem_block;
        if (rst_i) begin
            m_mem_wait = 0; m_md_wait = 0; m_md_result = 0;
            m_wait_len = 0; m_stalls = 0; m_timeout = 0;
            return;
        end
        mem_block = M_mem_req_i && !dmem_ready_i;
        if (e[9] && m_stalls < CNT_MAX) m_stalls++;
        if (m_md_wait) begin
            if ((md_done_i || m_md_result) && !mem_block) begin
                m_md_wait = 0; m_md_result = 0;
            end else if (md_done_i) begin
                m_md_result = 1;
            end
        end else if (m_mem_wait) begin
            // Timeout once the wait has already run TIMEOUT cycles and memory is still not ready.
            if (!dmem_ready_i && m_wait_len == TIMEOUT) m_timeout = 1;
            m_wait_len++;
            if (dmem_ready_i) m_mem_wait = 0;
        end else if (mem_block) begin
            m_mem_wait = 1; m_wait_len = 0;
        end else if (E_is_md_i) begin
            m_md_wait = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [9:0] e;
        @(negedge clk_i);
        e = exp_outputs();
        check("ctrl_outputs", 32'(dut_outputs()), 32'(e));
        check("stall_cnt", 32'(stall_cnt_o), 32'(m_stalls));
        check("timeout", 32'(timeout_o), 32'(m_timeout));
        @(posedge clk_i);
        model_update(e);
        #1;
    endtask

    task automatic idle();
        D_rs1_i = 5'd0; D_rs2_i = 5'd0; E_rd_i = 5'd0;
        D_rs1_used_i = 0; D_rs2_used_i = 0; E_reg_wen_i = 0; E_is_load_i = 0;
        E_is_md_i = 0; E_mispredict_i = 0; md_done_i = 0;
        M_mem_req_i = 0; dmem_ready_i = 0;
    endtask

    initial begin
        logic [CNT_W-1:0] cnt0;
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        #1;
        check("reset_bubbles", 32'({D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o, F_stall_o}), 32'(5'b11110));
        check("reset_cnt", 32'(stall_cnt_o), 32'd0);
        rst_i = 1'b0;

        // Load-use: ld x5 in E, add x6,x5,x1 in D
        E_is_load_i = 1; E_reg_wen_i = 1; E_rd_i = 5'd5;
        D_rs1_i = 5'd5; D_rs1_used_i = 1; D_rs2_i = 5'd1; D_rs2_used_i = 1;
        #1 check("load_use", 32'({F_stall_o, D_stall_o, E_bubble_o, E_stall_o}), 32'(4'b1110));
        tick();
        idle();
        #1 check("load_use_done", 32'(F_stall_o), 32'd0);
        tick();
        E_is_load_i = 1; E_reg_wen_i = 1; E_rd_i = 5'd0; D_rs1_i = 5'd0; D_rs1_used_i = 1;
        #1 check("load_x0", 32'({F_stall_o, E_bubble_o}), 32'd0);
        tick();

        // Mispredict in RUN
        idle();
        E_mispredict_i = 1;
        cnt0 = stall_cnt_o;
        #1 check("mispredict", 32'({D_bubble_o, E_bubble_o, F_stall_o, D_stall_o}), 32'(4'b1100));
        tick();
        idle();
        #1 check("mispredict_cnt", 32'(stall_cnt_o), 32'(cnt0));
        tick();

        // Memory wait, ready low for 3 cycles
        cnt0 = stall_cnt_o;
        M_mem_req_i = 1; dmem_ready_i = 0;
        repeat (3) begin
            #1 check("mem_hold", 32'({F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_bubble_o}), 32'(5'b11111));
            tick();
        end
        dmem_ready_i = 1;
        #1 check("mem_release", 32'(M_stall_o), 32'd0);
        check("mem_stall_cnt", 32'(CNT_W'(stall_cnt_o - cnt0)), 32'd3);
        tick();
        idle();
        tick();

        // Mul/div: launch, 3 wait cycles, done on cycle 4
        E_is_md_i = 1;
        #1 check("md_start", 32'(md_start_o), 32'd1);
        tick();
        repeat (3) begin
            #1 check("md_hold", 32'({F_stall_o, D_stall_o, E_stall_o, M_bubble_o, md_start_o}), 32'(5'b11110));
            tick();
        end
        md_done_i = 1;
        #1 check("md_done", 32'({E_stall_o, M_bubble_o}), 32'd0);
        tick();
        idle();
        tick();

        // md_done arrives under a memory hold; E released once memory is ready
        E_is_md_i = 1;
        tick();
        tick();
        M_mem_req_i = 1; dmem_ready_i = 0; md_done_i = 1;
        #1 check("overlap_mem_first", 32'({M_stall_o, M_bubble_o, W_bubble_o}), 32'(3'b101));
        tick();
        md_done_i = 0;
        tick();
        dmem_ready_i = 1;
        #1 check("overlap_release", 32'({E_stall_o, M_bubble_o}), 32'd0);
        tick();
        idle();
        tick();

        // Timeout boundary: 5 low cycles stay clear, 6 set it
        M_mem_req_i = 1; dmem_ready_i = 0;
        repeat (5) tick();
        dmem_ready_i = 1;
        tick();
        idle();
        #1 check("no_timeout_5", 32'(timeout_o), 32'd0);
        tick();
        M_mem_req_i = 1; dmem_ready_i = 0;
        repeat (6) tick();
        dmem_ready_i = 1;
        tick();
        idle();
        repeat (3) tick();
        #1 check("timeout_sticky", 32'(timeout_o), 32'd1);

        // Reset in the middle of a memory wait
        M_mem_req_i = 1; dmem_ready_i = 0;
        repeat (2) tick();
        rst_i = 1;
        #1 check("rst_forced", 32'(dut_outputs()), 32'(10'b00000_1111_0));
        tick();
        rst_i = 0;
        idle();
        #1 check("rst_cnt", 32'({stall_cnt_o, timeout_o}), 32'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_i          = ($urandom_range(0, 99) < 2);
            D_rs1_i        = 5'($urandom_range(0, 3));
            D_rs2_i        = 5'($urandom_range(0, 3));
            E_rd_i         = 5'($urandom_range(0, 3));
            D_rs1_used_i   = 1'($urandom_range(0, 1));
            D_rs2_used_i   = 1'($urandom_range(0, 1));
            E_reg_wen_i    = ($urandom_range(0, 99) < 70);
            E_is_load_i    = ($urandom_range(0, 99) < 40);
            E_is_md_i      = ($urandom_range(0, 99) < 15);
            E_mispredict_i = ($urandom_range(0, 99) < 20);
            md_done_i      = ($urandom_range(0, 99) < 25);
            M_mem_req_i    = ($urandom_range(0, 99) < 30);
            dmem_ready_i   = ($urandom_range(0, 99) < 50);
            tick();
        end

        // Long memory wait drives the stall counter into saturation
        rst_i = 0;
        idle();
        M_mem_req_i = 1; dmem_ready_i = 0;
        repeat (CNT_MAX + 20) tick();
        #1 check("stall_saturate", 32'(stall_cnt_o), 32'(CNT_MAX));
        check("timeout_long", 32'(timeout_o), 32'd1);
        dmem_ready_i = 1;
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
